serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 23 ++
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor_fs_cell.sv | 33 +++
 rtl/serial_subtractor.sv | 98 +++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Purpose  : Shared types and constants for the bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter width: ceil(log2(width)), never below one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Operand/result handshake bundle for serial_subtractor.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_default_width
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (output start, a, b, input  busy, done, diff, borrow_out);
    modport slave  (input  start, a, b, output busy, done, diff, borrow_out);
endinterface
`default_nettype wire

// File: rtl/serial_subtractor_fs_cell.sv
`default_nettype none
// ============================================================================
// Module   : half_subtractor / fs_cell
// Purpose  : Single-bit half subtractor and the full subtractor built from two.
// Revision : 1.0 - initial release
// ============================================================================
module half_subtractor (
    input  wire logic a,
    input  wire logic b,
    output logic      d,
    output logic      bout
);
    assign d    = a ^ b;
    assign bout = ~a & b;
endmodule

module fs_cell (
    input  wire logic a,
    input  wire logic b,
    input  wire logic bin,
    output logic      d,
    output logic      bout
);
    logic w_d1;
    logic w_b1;
    logic w_b2;

    half_subtractor u_hs_ab (.a(a),    .b(b),   .d(w_d1), .bout(w_b1));
    half_subtractor u_hs_bi (.a(w_d1), .b(bin), .d(d),    .bout(w_b2));

    assign bout = w_b1 | w_b2;
endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : LSB-first bit-serial subtractor, one bit per clock, start/busy/done.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_bin;
    logic             r_borrow_out;
    logic             w_d;
    logic             w_bout;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_res_cat;
    logic [WIDTH-1:0] w_res_next;

    // The DONE cycle doubles as an accept slot so a held start yields WIDTH+1 cycles/op.
    assign w_accept   = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
    assign w_res_cat  = {w_d, r_res};
    assign w_res_next = w_res_cat[WIDTH:1];

    fs_cell u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = SHIFT;
            SHIFT:   if (w_last)    w_state_next = DONE;
            DONE:    w_state_next = bus.start ? SHIFT : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_bin        <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_res <= '0;
            r_bin <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res_next;
            r_bin <= w_bout;
            if (w_last) begin
                r_diff       <= w_res_next;
                r_borrow_out <= w_bout;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.busy       = (r_state == SHIFT);
    assign bus.done       = (r_state == DONE);
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;

endmodule
`default_nettype wire
